// File: rtl/mul_pipe.sv
// Fully pipelined RV M-extension multiplier (MUL/MULH/MULHSU/MULHU), STAGES-deep, valid/ready with flush.
// Optional: define MUL_ZERO_SKIP_EN to retire zero-operand requests in one cycle when the pipeline is empty.
module mul_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  input  logic            flush_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            ready_o,
  output logic            valid_o,
  input  logic            rdy_i,
  output logic [XLEN-1:0] result_o
);

  // Product kept modulo 2^(2*XLEN): the low 2*XLEN bits of the signed (2*XLEN+2)-bit product.
  localparam int unsigned PW  = 2 * XLEN;
  localparam int unsigned NCH = STAGES - 1;
  localparam int unsigned CW  = (XLEN + NCH) / NCH;
  localparam int unsigned BW  = NCH * CW;

  // One b-chunk partial product; the most significant chunk carries b's sign.
  function automatic logic [PW-1:0] pp(input logic [PW-1:0] a, input logic [CW-1:0] c,
                                       input logic top);
    logic [PW-1:0] cx;
    cx = {{(PW-CW){top & c[CW-1]}}, c};
    return a * cx;
  endfunction

  logic [STAGES:1] v;
  logic [PW-1:0]   acc  [1:NCH];
  logic [PW-1:0]   a_r  [1:NCH];
  logic [BW-1:0]   b_r  [1:NCH];
  logic [1:0]      op_r [1:NCH];

  logic            stall;
  logic            accept;
  logic            zero_skip;
  logic            sa;
  logic            sb;
  logic [PW-1:0]   a_ext;
  logic [BW-1:0]   b_ext;
  logic [XLEN-1:0] sel;

  assign stall   = v[STAGES] & ~rdy_i;
  assign valid_o = v[STAGES] & ~flush_i;
  assign ready_o = ~(valid_o & ~rdy_i);
  assign accept  = req_i & ready_o & ~flush_i;

`ifdef MUL_ZERO_SKIP_EN
  assign zero_skip = accept & ~(|v) & (~(|a_i) | ~(|b_i));
`else
  assign zero_skip = 1'b0;
`endif

  // Operand extension: a signed for MULH/MULHSU, b signed for MULH only.
  assign sa    = op_i[0] ^ op_i[1];
  assign sb    = (op_i == 2'b01);
  assign a_ext = {{(PW-XLEN){sa & a_i[XLEN-1]}}, a_i};
  assign b_ext = {{(BW-XLEN){sb & b_i[XLEN-1]}}, b_i};

  assign sel = (op_r[NCH] == 2'b00) ? acc[NCH][XLEN-1:0] : acc[NCH][PW-1:XLEN];

  // Stage-valid bits and the registered result.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v        <= '0;
      result_o <= '0;
    end else if (flush_i) begin
      v <= '0;
    end else if (!stall) begin
      v <= {v[STAGES-1:1], accept & ~zero_skip};
      if (zero_skip) begin
        v[STAGES] <= 1'b1;
        result_o  <= '0;
      end else if (v[STAGES-1]) begin
        result_o <= sel;
      end
    end
  end

  // Reduction datapath: chunk 0 at capture, chunk s on the way into stage s+1.
  always_ff @(posedge clk_i) begin
    if (!stall) begin
      acc[1]  <= pp(a_ext, b_ext[CW-1:0], NCH == 1);
      a_r[1]  <= a_ext;
      b_r[1]  <= b_ext >> CW;
      op_r[1] <= op_i;
      for (int s = 1; s < NCH; s++) begin
        acc[s+1]  <= acc[s] + (pp(a_r[s], b_r[s][CW-1:0], s == NCH - 1) << (s * CW));
        a_r[s+1]  <= a_r[s];
        b_r[s+1]  <= b_r[s] >> CW;
        op_r[s+1] <= op_r[s];
      end
    end
  end

endmodule
